// File: rtl/imm_enc_pkg.sv
// Shared definitions for the immediate encoder and the core's immediate
// generator. Both import this package so the format codes cannot drift apart.
package imm_enc_pkg;

  // Width of the immediate format code.
  localparam int EXTOP_W = 3;

  // Immediate format codes. Values 3'b101..3'b111 are unassigned.
  localparam logic [EXTOP_W-1:0] EXT_I = 3'b000;
  localparam logic [EXTOP_W-1:0] EXT_U = 3'b001;
  localparam logic [EXTOP_W-1:0] EXT_S = 3'b010;
  localparam logic [EXTOP_W-1:0] EXT_B = 3'b011;
  localparam logic [EXTOP_W-1:0] EXT_J = 3'b100;

endpackage

// File: rtl/imm_enc_fields.sv
// Combinational core of the immediate encoder: checks that the immediate fits
// the chosen RV32 format and scatters its bits into the base instruction.
// When the immediate does not fit, or the format code is unassigned, the base
// word passes through untouched and o_err is raised.
module imm_enc_fields
  import imm_enc_pkg::*;
(
  input  logic [EXTOP_W-1:0] i_extop,
  input  logic [31:0]        i_imm,
  input  logic [31:0]        i_base,
  output logic [31:0]        o_inst,
  output logic               o_err
);

  // Sign-extension checks: the named upper bits must all be copies of the
  // top bit of the encodable field.
  logic w_fit_12;
  logic w_fit_13;
  logic w_fit_21;
  logic w_u_aligned;
  logic w_even;

  assign w_fit_12    = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_fit_13    = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_fit_21    = (&i_imm[31:20]) | ~(|i_imm[31:20]);
  assign w_u_aligned = ~(|i_imm[11:0]);
  assign w_even      = ~i_imm[0];

  // Format select: replace only the immediate bit positions of the chosen format.
  always_comb begin
    o_inst = i_base;
    o_err  = 1'b0;
    case (i_extop)
      EXT_I: begin
        if (w_fit_12) o_inst[31:20] = i_imm[11:0];
        else          o_err         = 1'b1;
      end
      EXT_U: begin
        if (w_u_aligned) o_inst[31:12] = i_imm[31:12];
        else             o_err         = 1'b1;
      end
      EXT_S: begin
        if (w_fit_12) begin
          o_inst[31:25] = i_imm[11:5];
          o_inst[11:7]  = i_imm[4:0];
        end else begin
          o_err = 1'b1;
        end
      end
      EXT_B: begin
        if (w_fit_13 && w_even) begin
          o_inst[31]    = i_imm[12];
          o_inst[30:25] = i_imm[10:5];
          o_inst[11:8]  = i_imm[4:1];
          o_inst[7]     = i_imm[11];
        end else begin
          o_err = 1'b1;
        end
      end
      EXT_J: begin
        if (w_fit_21 && w_even) begin
          o_inst[31]    = i_imm[20];
          o_inst[30:21] = i_imm[10:1];
          o_inst[20]    = i_imm[11];
          o_inst[19:12] = i_imm[19:12];
        end else begin
          o_err = 1'b1;
        end
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_enc.sv
// Immediate encoder top: two-stage pipeline around imm_enc_fields with
// valid/ready handshakes on both sides and a saturating count of errored
// results handed to the consumer.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid && ready. A producer holding valid keeps its data stable until the
// transfer; in_ready is combinational from out_ready and the stage valids,
// and is 0 while rst_n is low.
module imm_enc #(
  parameter int CNT_W   = 16,
  parameter int EXTOP_W = imm_enc_pkg::EXTOP_W  // must equal the package width
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXTOP_W-1:0] extop,
  input  logic [31:0]        imm,
  input  logic [31:0]        base,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        inst,
  output logic               err,
  output logic [CNT_W-1:0]   err_cnt
);

  import imm_enc_pkg::*;

  // Stage 1: raw request.
  logic               r_s1_valid;
  logic [EXTOP_W-1:0] r_s1_extop;
  logic [31:0]        r_s1_imm;
  logic [31:0]        r_s1_base;

  // Stage 2: encoded result.
  logic               r_s2_valid;
  logic [31:0]        r_s2_inst;
  logic               r_s2_err;
  logic [CNT_W-1:0]   r_err_cnt;

  logic               w_s2_free;
  logic               w_s1_free;
  logic [31:0]        w_inst;
  logic               w_err;
  logic               w_deliver_err;

  // A stage may load when it is empty or its contents leave this cycle.
  assign w_s2_free     = !r_s2_valid || out_ready;
  assign w_s1_free     = !r_s1_valid || w_s2_free;
  assign w_deliver_err = r_s2_valid && out_ready && r_s2_err;

  assign in_ready  = rst_n && w_s1_free;
  assign out_valid = r_s2_valid;
  assign inst      = r_s2_inst;
  assign err       = r_s2_err;
  assign err_cnt   = r_err_cnt;

  imm_enc_fields u_fields (
    .i_extop (r_s1_extop),
    .i_imm   (r_s1_imm),
    .i_base  (r_s1_base),
    .o_inst  (w_inst),
    .o_err   (w_err)
  );

  // Stage 1 capture: load a new request whenever the stage can advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_extop <= '0;
      r_s1_imm   <= '0;
      r_s1_base  <= '0;
    end else if (w_s1_free) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_extop <= extop;
        r_s1_imm   <= imm;
        r_s1_base  <= base;
      end
    end
  end

  // Stage 2 capture: result is held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_inst  <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_inst <= w_inst;
        r_s2_err  <= w_err;
      end
    end
  end

  // Error counter: counts errored beats as they are taken, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_deliver_err && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_enc.sv
// Self-checking bench for imm_enc. A second instance with a 2-bit counter
// shares the stimulus so counter saturation is reachable in a few beats.
module tb_imm_enc;

  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  extop;
  logic [31:0] imm;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        err;
  logic [CNT_W-1:0] err_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_inst;
  logic        s_err;
  logic [1:0]  s_err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  logic [31:0] exp_q[$];
  logic [2:0]  exp_ext_q[$];
  logic [31:0] exp_imm_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  imm_enc #(.CNT_W(CNT_W), .EXTOP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .extop(extop), .imm(imm), .base(base), .out_valid(out_valid),
    .out_ready(out_ready), .inst(inst), .err(err), .err_cnt(err_cnt)
  );

  imm_enc #(.CNT_W(2), .EXTOP_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .extop(extop), .imm(imm), .base(base), .out_valid(s_out_valid),
    .out_ready(out_ready), .inst(s_inst), .err(s_err), .err_cnt(s_err_cnt)
  );

  // ---------------- reference model ----------------
  function automatic logic ref_fits(input logic [2:0] x, input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    case (x)
      3'd0, 3'd2: return (s >= -2048) && (s <= 2047);
      3'd1:       return (v % 4096) == 0;
      3'd3:       return ((v % 2) == 0) && (s >= -4096) && (s <= 4095);
      3'd4:       return ((v % 2) == 0) && (s >= -1048576) && (s <= 1048575);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_encode(input logic [2:0] x, input logic [31:0] v,
                                             input logic [31:0] b);
    if (!ref_fits(x, v)) return b;
    case (x)
      3'd0: return (b & 32'h000FFFFF) | ((v & 32'hFFF) << 20);
      3'd1: return (b & 32'h00000FFF) | (v & 32'hFFFFF000);
      3'd2: return (b & ~32'hFE000F80) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
      3'd3: return (b & ~32'hFE000F80) | (((v >> 12) & 32'h1) << 31)
                   | (((v >> 5) & 32'h3F) << 25) | (((v >> 1) & 32'hF) << 8)
                   | (((v >> 11) & 32'h1) << 7);
      default: return (b & 32'h00000FFF) | (((v >> 20) & 32'h1) << 31)
                   | (((v >> 1) & 32'h3FF) << 21) | (((v >> 11) & 32'h1) << 20)
                   | (((v >> 12) & 32'hFF) << 12);
    endcase
  endfunction

  // Immediate generator: recovers the immediate from an encoded word.
  function automatic logic [31:0] ref_decode(input logic [2:0] x, input logic [31:0] w);
    int s;
    s = $signed(w);
    case (x)
      3'd0: return 32'(s >>> 20);
      3'd1: return w & 32'hFFFFF000;
      3'd2: return 32'((s >>> 25) * 32) | ((w >> 7) & 32'h1F);
      3'd3: return 32'((s >>> 31) * 4096) | (((w >> 7) & 32'h1) << 11)
                   | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
      default: return 32'((s >>> 31) * 1048576) | (w & 32'h000FF000)
                   | (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
    endcase
  endfunction

  // Legal immediate for a format, biased toward both range ends.
  function automatic logic [31:0] gen_legal(input logic [2:0] x);
    int lo, hi, stp, n, k, sel;
    sel = int'($urandom_range(0, 7));
    if (x == 3'd1) begin
      if (sel == 0) return 32'h80000000;
      if (sel == 1) return 32'hFFFFF000;
      return $urandom & 32'hFFFFF000;
    end
    case (x)
      3'd3:    begin lo = -4096;    hi = 4094;    stp = 2; end
      3'd4:    begin lo = -1048576; hi = 1048574; stp = 2; end
      default: begin lo = -2048;    hi = 2047;    stp = 1; end
    endcase
    n = (hi - lo) / stp;
    if (sel == 0)      k = 0;
    else if (sel == 1) k = n;
    else               k = int'($urandom_range(0, n));
    return 32'(lo + k * stp);
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: apply inputs, sample at the falling edge, return just
  // after the next rising edge.
  task automatic step(input logic v, input logic [2:0] x, input logic [31:0] im,
                      input logic [31:0] b, input logic ordy,
                      output logic acc, output logic dlv, output logic ovld,
                      output logic irdy, output logic [31:0] oi, output logic oe);
    in_valid  = v;
    extop     = x;
    imm       = im;
    base      = b;
    out_ready = ordy;
    @(negedge clk);
    irdy = in_ready;
    acc  = in_valid && in_ready;
    ovld = out_valid;
    dlv  = out_valid && out_ready;
    oi   = inst;
    oe   = err;
    @(posedge clk);
    #1;
  endtask

  // Send one beat with out_ready high; lat = cycles from accept to delivery.
  task automatic xfer_one(input logic [2:0] x, input logic [31:0] im, input logic [31:0] b,
                          output int lat, output logic [31:0] oi, output logic oe);
    logic acc, dlv, ovld, irdy;
    int k;
    acc = 1'b0;
    dlv = 1'b0;
    lat = -1;
    k = 0;
    while (!acc && k < 20) begin
      step(1'b1, x, im, b, 1'b1, acc, dlv, ovld, irdy, oi, oe);
      k++;
    end
    k = 0;
    while (acc && !dlv && k < 20) begin
      step(1'b0, x, im, b, 1'b1, acc, dlv, ovld, irdy, oi, oe);
      acc = 1'b1;
      k++;
    end
    if (dlv) lat = k;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; extop = '0; imm = '0; base = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h want=00000000", inst); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = 0;
  endtask

  task automatic test_directed();
    int lat; logic [31:0] oi; logic oe;
    xfer_one(3'b000, 32'hFFFFFFFF, 32'h00000093, lat, oi, oe);
    checks++; if (lat !== 2) begin errors++; $display("FAIL i_latency got=%0d want=2", lat); end
    checks++; if (oi !== 32'hFFF00093) begin errors++; $display("FAIL i_inst got=%h want=fff00093", oi); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL i_err got=%b want=0", oe); end
    xfer_one(3'b011, 32'hFFFFFFFC, 32'h00000063, lat, oi, oe);
    checks++; if (oi !== 32'hFE000EE3) begin errors++; $display("FAIL b_inst got=%h want=fe000ee3", oi); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL b_err got=%b want=0", oe); end
    checks++; if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL ok_err_cnt got=%0d want=%0d", err_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic acc, dlv, ovld, irdy, oe; logic [31:0] oi;
    logic [31:0] got_inst[2]; int got_at[2]; int n_acc, n_got;
    logic [2:0] xs[2]; logic [31:0] ims[2]; logic [31:0] bs[2];
    xs[0] = 3'b001; ims[0] = 32'h12345000; bs[0] = 32'h000002B7;
    xs[1] = 3'b100; ims[1] = 32'h00000800; bs[1] = 32'h000000EF;
    n_acc = 0; n_got = 0; got_at[0] = -1; got_at[1] = -1;
    got_inst[0] = '0; got_inst[1] = '0;
    for (int c = 0; c < 10; c++) begin
      if (n_acc < 2) step(1'b1, xs[n_acc], ims[n_acc], bs[n_acc], 1'b1, acc, dlv, ovld, irdy, oi, oe);
      else           step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, acc, dlv, ovld, irdy, oi, oe);
      if (acc) n_acc++;
      if (dlv && n_got < 2) begin got_inst[n_got] = oi; got_at[n_got] = c; n_got++; end
    end
    checks++; if (n_got !== 2) begin errors++; $display("FAIL b2b_count got=%0d want=2", n_got); end
    checks++; if (got_inst[0] !== 32'h123452B7) begin errors++; $display("FAIL b2b_u_inst got=%h want=123452b7", got_inst[0]); end
    checks++; if (got_inst[1] !== 32'h001000EF) begin errors++; $display("FAIL b2b_j_inst got=%h want=001000ef", got_inst[1]); end
    checks++; if (got_at[0] !== 2) begin errors++; $display("FAIL b2b_first_cycle got=%0d want=2", got_at[0]); end
    checks++; if (got_at[1] !== got_at[0] + 1) begin errors++; $display("FAIL b2b_consecutive got=%0d want=%0d", got_at[1], got_at[0] + 1); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] oi; logic oe;
    xfer_one(3'b011, 32'h00000003, 32'h00000063, lat, oi, oe);
    exp_cnt++;
    checks++; if (oi !== 32'h00000063) begin errors++; $display("FAIL err_b_inst got=%h want=00000063", oi); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL err_b_err got=%b want=1", oe); end
    checks++; if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL err_b_cnt got=%0d want=%0d", err_cnt, exp_cnt); end
    xfer_one(3'b000, 32'h00000800, 32'h00000093, lat, oi, oe);
    exp_cnt++;
    checks++; if (oi !== 32'h00000093) begin errors++; $display("FAIL err_i_inst got=%h want=00000093", oi); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL err_i_err got=%b want=1", oe); end
    checks++; if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL err_i_cnt got=%0d want=%0d", err_cnt, exp_cnt); end
    xfer_one(3'b111, 32'h00000000, 32'h00000013, lat, oi, oe);
    exp_cnt++;
    checks++; if (oi !== 32'h00000013) begin errors++; $display("FAIL err_ext_inst got=%h want=00000013", oi); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL err_ext_err got=%b want=1", oe); end
    checks++; if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL err_ext_cnt got=%0d want=%0d", err_cnt, exp_cnt); end
  endtask

  task automatic test_saturate();
    int lat; logic [31:0] oi; logic oe;
    // U immediate with low bits set, then S immediate out of range.
    xfer_one(3'b001, 32'h00001001, 32'h00000037, lat, oi, oe);
    exp_cnt++;
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL sat_u_err got=%b want=1", oe); end
    xfer_one(3'b010, 32'hFFFFF7FF, 32'h00002023, lat, oi, oe);
    exp_cnt++;
    checks++; if (oi !== 32'h00002023) begin errors++; $display("FAIL sat_s_inst got=%h want=00002023", oi); end
    checks++; if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL sat_main_cnt got=%0d want=%0d", err_cnt, exp_cnt); end
    checks++; if (s_err_cnt !== 2'd3) begin errors++; $display("FAIL sat_small_cnt got=%0d want=3", s_err_cnt); end
  endtask

  task automatic test_backpressure();
    logic acc, dlv, ovld, irdy, oe; logic [31:0] oi;
    logic [31:0] ims[4]; logic [31:0] bs[4]; logic [31:0] snap;
    int n_acc, n_got, k; logic have_snap;
    for (int i = 0; i < 4; i++) begin
      ims[i] = 32'(i * 37 - 40);
      bs[i]  = 32'h00000013 | (32'(i + 1) << 7);
    end
    n_acc = 0; n_got = 0; have_snap = 1'b0; snap = '0; irdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(n_acc < 4, 3'b000, ims[n_acc % 4], bs[n_acc % 4], 1'b0, acc, dlv, ovld, irdy, oi, oe);
      if (acc) n_acc++;
      if (ovld && !have_snap) begin snap = oi; have_snap = 1'b1; end
      else if (ovld) begin
        checks++; if (oi !== snap) begin errors++; $display("FAIL bp_stable got=%h want=%h", oi, snap); end
      end
    end
    checks++; if (n_acc !== 2) begin errors++; $display("FAIL bp_accepted got=%0d want=2", n_acc); end
    checks++; if (irdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", irdy); end
    checks++; if (snap !== ref_encode(3'b000, ims[0], bs[0])) begin errors++; $display("FAIL bp_snap got=%h want=%h", snap, ref_encode(3'b000, ims[0], bs[0])); end
    k = 0;
    while (n_got < 4 && k < 30) begin
      step(n_acc < 4, 3'b000, ims[n_acc % 4], bs[n_acc % 4], 1'b1, acc, dlv, ovld, irdy, oi, oe);
      if (dlv) begin
        checks++; if (oi !== ref_encode(3'b000, ims[n_got], bs[n_got])) begin errors++; $display("FAIL bp_order beat=%0d got=%h want=%h", n_got, oi, ref_encode(3'b000, ims[n_got], bs[n_got])); end
        n_got++;
      end
      if (acc) n_acc++;
      k++;
    end
    checks++; if (n_got !== 4) begin errors++; $display("FAIL bp_delivered got=%0d want=4", n_got); end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, acc, dlv, ovld, irdy, oi, oe);
      checks++; if (dlv !== 1'b0) begin errors++; $display("FAIL bp_extra got=%b want=0", dlv); end
    end
  endtask

  task automatic test_random_roundtrip(input int n_beats);
    logic acc, dlv, ovld, irdy, oe; logic [31:0] oi;
    logic v; logic [2:0] x; logic [31:0] im, b;
    logic [31:0] e_inst, e_imm; logic [2:0] e_ext;
    int sent, got, cyc;
    v = 1'b0; x = '0; im = '0; b = '0;
    sent = 0; got = 0; cyc = 0;
    while (got < n_beats && cyc < 4 * n_beats + 100) begin
      if (!v && sent < n_beats && $urandom_range(0, 3) != 0) begin
        v  = 1'b1;
        x  = 3'($urandom_range(0, 4));
        im = gen_legal(x);
        b  = $urandom;
      end
      step(v, x, im, b, $urandom_range(0, 3) != 0, acc, dlv, ovld, irdy, oi, oe);
      if (dlv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rnd_unexpected got=%h want=none", oi);
        end else begin
          e_inst = exp_q.pop_front(); e_ext = exp_ext_q.pop_front(); e_imm = exp_imm_q.pop_front();
          checks++; if (oi !== e_inst) begin errors++; $display("FAIL rnd_inst ext=%0d imm=%h got=%h want=%h", e_ext, e_imm, oi, e_inst); end
          checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rnd_err ext=%0d imm=%h got=%b want=0", e_ext, e_imm, oe); end
          checks++; if (ref_decode(e_ext, oi) !== e_imm) begin errors++; $display("FAIL rnd_roundtrip ext=%0d got=%h want=%h", e_ext, ref_decode(e_ext, oi), e_imm); end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(ref_encode(x, im, b));
        exp_ext_q.push_back(x);
        exp_imm_q.push_back(im);
        sent++;
        v = 1'b0;
      end
      cyc++;
    end
    checks++; if (got !== n_beats) begin errors++; $display("FAIL rnd_timeout got=%0d want=%0d", got, n_beats); end
    checks++; if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL rnd_err_cnt got=%0d want=%0d", err_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    logic acc, dlv, ovld, irdy, oe; logic [31:0] oi;
    for (int c = 0; c < 3; c++)
      step(1'b1, 3'b111, 32'h0, 32'h00000013, 1'b0, acc, dlv, ovld, irdy, oi, oe);
    rst_n = 1'b0;
    step(1'b1, 3'b111, 32'h0, 32'h00000013, 1'b1, acc, dlv, ovld, irdy, oi, oe);
    checks++; if (irdy !== 1'b0) begin errors++; $display("FAIL mid_in_ready got=%b want=0", irdy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL mid_err_cnt got=%0d want=0", err_cnt); end
    checks++; if (s_err_cnt !== 2'd0) begin errors++; $display("FAIL mid_small_cnt got=%0d want=0", s_err_cnt); end
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, acc, dlv, ovld, irdy, oi, oe);
      checks++; if (ovld !== 1'b0) begin errors++; $display("FAIL mid_ghost got=%b want=0", ovld); end
    end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL mid_cnt_after got=%0d want=0", err_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_errors();
    test_saturate();
    test_backpressure();
    test_random_roundtrip(10000);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
